// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: forms a W x W unsigned product by stepping one external
// 2-bit x 2-bit combinational multiplier over every digit pair (i outer,
// j inner) and shift-accumulating each 4-bit partial product.
module mult_seq_ctrl #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic [2*W-1:0]  p,
  output logic [1:0]      mul_a,
  output logic [1:0]      mul_b,
  input  logic [3:0]      mul_c
);

  localparam int D  = W / 2;                      // digits per operand
  localparam int IW = (D > 1) ? $clog2(D) : 1;    // digit index width
  localparam int ND = 1 << IW;                    // digit table depth (power of two)
  localparam int PW = 2 * W;                      // product width
  localparam int SW = IW + 2;                     // shift amount width, holds 2*(i+j)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [PW-1:0] acc;
  logic [IW-1:0] i;
  logic [IW-1:0] j;

  logic [1:0]    a_dig [ND];
  logic [1:0]    b_dig [ND];
  logic [SW-1:0] shift;
  logic [PW-1:0] term;
  logic [PW-1:0] sum;
  logic          last_j;
  logic          last;

  // Split the latched operands into 2-bit digits. The table is padded to a
  // power of two so any index value is in range; padding digits read as 0.
  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dig
      if (gi < D) begin : g_real
        assign a_dig[gi] = a_r[2*gi +: 2];
        assign b_dig[gi] = b_r[2*gi +: 2];
      end else begin : g_pad
        assign a_dig[gi] = 2'b00;
        assign b_dig[gi] = 2'b00;
      end
    end
  endgenerate

  // Weight of the current digit pair is 4^(i+j), i.e. a left shift by 2*(i+j).
  assign last_j = (j == IW'(D - 1));
  assign last   = last_j && (i == IW'(D - 1));
  assign shift  = {1'b0, i, 1'b0} + {1'b0, j, 1'b0};
  assign term   = PW'(mul_c) << shift;
  assign sum    = acc + term;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs; digits are only presented in RUN.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mul_a      = 2'b00;
    mul_b      = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        mul_a = a_dig[i];
        mul_b = b_dig[j];
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, digit indices, accumulation and result register.
  // mul_c is consumed only in RUN; the result register moves only on the
  // final digit pair, so a reset mid-run leaves p at 0 with no completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      i   <= '0;
      j   <= '0;
      p   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          if (last) begin
            p <= sum;
            i <= '0;
            j <= '0;
          end else if (last_j) begin
            j <= '0;
            i <= i + IW'(1);
          end else begin
            j <= j + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: table-driven directed checks of mult_seq_ctrl at W=8 and
// W=2, with a behavioural 2x2 multiplier placed beside each instance.
module tb_mult_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // W=8 instance
  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] p8;
  logic [1:0]  ma8, mb8;
  logic [3:0]  mc8;
  assign mc8 = {2'b00, ma8} * {2'b00, mb8};

  // W=2 instance
  logic        start2;
  logic [1:0]  a2, b2;
  logic        busy2, done2;
  logic [3:0]  p2;
  logic [1:0]  ma2, mb2;
  logic [3:0]  mc2;
  assign mc2 = {2'b00, ma2} * {2'b00, mb2};

  mult_seq_ctrl #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8),
    .mul_a(ma8), .mul_b(mb8), .mul_c(mc8)
  );

  mult_seq_ctrl #(.W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .p(p2),
    .mul_a(ma2), .mul_b(mb2), .mul_c(mc2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec8_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] p;
  } vec2_t;

  vec8_t tbl8[6];
  vec2_t tbl2[16];

  // Observe one W=8 operation; called right after the start edge.
  task automatic watch8(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [15:0] ep, input logic [15:0] p_before,
                        input string nm);
    int first;
    int busy_c;
    int done_c;
    bit p_moved;
    bit dig_bad;
    int ii;
    int jj;
    first = -1; busy_c = 0; done_c = 0; p_moved = 0; dig_bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) busy_c++;
      if (done8) begin
        done_c++;
        if (first < 0) first = n;
        chk({nm, " p"}, 32'(p8), 32'(ep));
        chk({nm, " mul in DONE"}, 32'({ma8, mb8}), 32'd0);
      end else if (first < 0 && p8 !== p_before) begin
        p_moved = 1'b1;
      end
      if (n < 16) begin
        ii = n / 4;
        jj = n % 4;
        if (ma8 !== ta[2*ii +: 2] || mb8 !== tb_[2*jj +: 2]) dig_bad = 1'b1;
      end
    end
    chk({nm, " latency"}, 32'(first), 32'd16);
    chk({nm, " done count"}, 32'(done_c), 32'd1);
    chk({nm, " busy cycles"}, 32'(busy_c), 32'd17);
    chk({nm, " p early change"}, 32'(p_moved), 32'd0);
    chk({nm, " digit sequence"}, 32'(dig_bad), 32'd0);
    chk({nm, " p hold"}, 32'(p8), 32'(ep));
    $display("op W=8 %s a=%0d b=%0d p=%0d latency=%0d", nm, ta, tb_, p8, first);
  endtask

  initial begin
    logic [15:0] pb;
    int first;
    int done_c;

    tbl8[0] = '{a: 8'd3,    b: 8'd5,    p: 16'd15};
    tbl8[1] = '{a: 8'd255,  b: 8'd255,  p: 16'hFE01};
    tbl8[2] = '{a: 8'hA7,   b: 8'h00,   p: 16'd0};
    tbl8[3] = '{a: 8'h00,   b: 8'hFF,   p: 16'd0};
    tbl8[4] = '{a: 8'hC0,   b: 8'h03,   p: 16'd576};
    tbl8[5] = '{a: 8'h81,   b: 8'h7E,   p: 16'd16254};

    tbl2[0]  = '{a: 2'd0, b: 2'd0, p: 4'd0};
    tbl2[1]  = '{a: 2'd0, b: 2'd1, p: 4'd0};
    tbl2[2]  = '{a: 2'd0, b: 2'd2, p: 4'd0};
    tbl2[3]  = '{a: 2'd0, b: 2'd3, p: 4'd0};
    tbl2[4]  = '{a: 2'd1, b: 2'd0, p: 4'd0};
    tbl2[5]  = '{a: 2'd1, b: 2'd1, p: 4'd1};
    tbl2[6]  = '{a: 2'd1, b: 2'd2, p: 4'd2};
    tbl2[7]  = '{a: 2'd1, b: 2'd3, p: 4'd3};
    tbl2[8]  = '{a: 2'd2, b: 2'd0, p: 4'd0};
    tbl2[9]  = '{a: 2'd2, b: 2'd1, p: 4'd2};
    tbl2[10] = '{a: 2'd2, b: 2'd2, p: 4'd4};
    tbl2[11] = '{a: 2'd2, b: 2'd3, p: 4'd6};
    tbl2[12] = '{a: 2'd3, b: 2'd0, p: 4'd0};
    tbl2[13] = '{a: 2'd3, b: 2'd1, p: 4'd3};
    tbl2[14] = '{a: 2'd3, b: 2'd2, p: 4'd6};
    tbl2[15] = '{a: 2'd3, b: 2'd3, p: 4'd9};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    chk("reset busy8", 32'(busy8), 32'd0);
    chk("reset done8", 32'(done8), 32'd0);
    chk("reset p8", 32'(p8), 32'd0);
    chk("reset mul8", 32'({ma8, mb8}), 32'd0);
    chk("reset busy2", 32'(busy2), 32'd0);
    chk("reset p2", 32'(p2), 32'd0);
    $display("reset: busy8=%0d done8=%0d p8=%0d", busy8, done8, p8);
    rst = 1'b0;

    // W=8 table
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a8 = tbl8[k].a; b8 = tbl8[k].b; start8 = 1'b1;
      pb = p8;
      @(posedge clk);
      watch8(tbl8[k].a, tbl8[k].b, tbl8[k].p, pb, $sformatf("vec%0d", k));
    end

    // start held high with operands changing during RUN; the DONE cycle must
    // not accept it, the following IDLE cycle must
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(posedge clk);
    first = -1;
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      if (done8 && first < 0) first = n;
      if (n == 16) chk("hold p", 32'(p8), 32'h3A8);
      if (n == 17) chk("hold idle gap", 32'(busy8), 32'd0);
      if (n < 16) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        a8 = 8'd5; b8 = 8'd7;
      end
      start8 = 1'b1;
    end
    chk("hold latency", 32'(first), 32'd16);
    $display("op W=8 hold a=18 b=52 p=%0d latency=%0d", p8, first);
    pb = p8;
    @(posedge clk);
    watch8(8'd5, 8'd7, 16'd35, pb, "hold second");

    // reset five cycles into RUN
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst done", 32'(done8), 32'd0);
    chk("midrst p", 32'(p8), 32'd0);
    chk("midrst mul", 32'({ma8, mb8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_c = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done8) done_c++;
    end
    chk("midrst no done", 32'(done_c), 32'd0);
    chk("midrst p after", 32'(p8), 32'd0);
    $display("midrst: busy8=%0d p8=%0d done pulses=%0d", busy8, p8, done_c);
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
    pb = p8;
    @(posedge clk);
    watch8(8'd200, 8'd100, 16'd20000, pb, "after reset");

    // W=2 table: one RUN cycle per operation
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a2 = tbl2[k].a; b2 = tbl2[k].b; start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      chk($sformatf("w2 vec%0d run busy", k), 32'(busy2), 32'd1);
      chk($sformatf("w2 vec%0d run done", k), 32'(done2), 32'd0);
      chk($sformatf("w2 vec%0d digits", k), 32'({ma2, mb2}), 32'({tbl2[k].a, tbl2[k].b}));
      @(negedge clk);
      chk($sformatf("w2 vec%0d done", k), 32'(done2), 32'd1);
      chk($sformatf("w2 vec%0d p", k), 32'(p2), 32'(tbl2[k].p));
      @(negedge clk);
      chk($sformatf("w2 vec%0d idle", k), 32'({busy2, done2}), 32'd0);
      chk($sformatf("w2 vec%0d p hold", k), 32'(p2), 32'(tbl2[k].p));
      $display("op W=2 a=%0d b=%0d p=%0d", tbl2[k].a, tbl2[k].b, p2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
